// File: rtl/wb_mux_n_if.sv
// Wishbone bus bundle shared between a master and the wb_mux_n address decoder.
// dat_o carries master write data, dat_i carries read data back to the master.
interface wishbone_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic                    we;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    stb;
    logic                    cyc;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (output adr, dat_o, we, sel, stb, cyc, input dat_i, ack, err, rty);
    modport slave  (input adr, dat_o, we, sel, stb, cyc, output dat_i, ack, err, rty);
endinterface

// File: rtl/wb_mux_n.sv
// N-port Wishbone address-decoding multiplexer with a registered per-transfer decode,
// a selection locked for the whole transfer, decode-error response and a response watchdog.
//
// state  | meaning
// IDLE   | no transfer; decode the master request when cyc&stb
// ACTIVE | latched slave strobed; waiting for ack/err/rty, abort or watchdog expiry
// ERR    | one-cycle err response to the master (decode miss or timeout)
module wb_mux_n #(
    parameter int NUM_SLAVES   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    wishbone_if.slave                          wb_master_if,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]   wbs_dat_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [NUM_SLAVES-1:0]              wbs_we_o,
    output logic [NUM_SLAVES*SELECT_WIDTH-1:0] wbs_sel_o,
    output logic [NUM_SLAVES-1:0]              wbs_stb_o,
    output logic [NUM_SLAVES-1:0]              wbs_cyc_o,
    input  logic [NUM_SLAVES-1:0]              wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]              wbs_err_i,
    input  logic [NUM_SLAVES-1:0]              wbs_rty_i,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   slv_addr,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   slv_msk,
    output logic                               busy,
    output logic                               decode_err,
    output logic                               timeout_err
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_ERR    = 2'd2;

    logic [1:0]            state, state_nxt;
    logic [IDX_W-1:0]      idx_q, hit_idx;
    logic                  hit;
    logic [CNT_W-1:0]      wd_cnt;
    logic                  req;
    logic                  sel_ack, sel_err, sel_rty, sel_resp;
    logic                  expire;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic [DATA_WIDTH-1:0] m_dat;
    logic                  m_ack, m_err, m_rty;

    assign req = wb_master_if.cyc & wb_master_if.stb;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (((wb_master_if.adr ^ slv_addr[i*ADDR_WIDTH +: ADDR_WIDTH])
                 & slv_msk[i*ADDR_WIDTH +: ADDR_WIDTH]) == '0) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign sel_ack  = wbs_ack_i[idx_q];
    assign sel_err  = wbs_err_i[idx_q];
    assign sel_rty  = wbs_rty_i[idx_q];
    assign sel_resp = sel_ack | sel_err | sel_rty;
    assign sel_dat  = wbs_dat_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign expire   = (TIMEOUT > 0) && (wd_cnt == CNT_LAST);

    always_comb begin
        state_nxt   = state;
        decode_err  = 1'b0;
        timeout_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        state_nxt = ST_ACTIVE;
                    end else begin
                        state_nxt  = ST_ERR;
                        decode_err = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                // A response in the expiry cycle still completes the transfer normally.
                if (!req || sel_resp) begin
                    state_nxt = ST_IDLE;
                end else if (expire) begin
                    state_nxt   = ST_ERR;
                    timeout_err = 1'b1;
                end
            end
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            idx_q  <= '0;
            wd_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req && hit) begin
                idx_q <= hit_idx;
            end
            if (TIMEOUT > 0 && state == ST_ACTIVE && state_nxt == ST_ACTIVE) begin
                if (wd_cnt != {CNT_W{1'b1}}) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = '0;
        wbs_stb_o = '0;
        wbs_cyc_o = '0;
        m_dat     = '0;
        m_ack     = 1'b0;
        m_err     = 1'b0;
        m_rty     = 1'b0;
        if (state == ST_ACTIVE) begin
            wbs_adr_o        = {NUM_SLAVES{wb_master_if.adr}};
            wbs_dat_o        = {NUM_SLAVES{wb_master_if.dat_o}};
            wbs_sel_o        = {NUM_SLAVES{wb_master_if.sel}};
            wbs_we_o[idx_q]  = wb_master_if.we;
            wbs_stb_o[idx_q] = wb_master_if.stb;
            wbs_cyc_o[idx_q] = wb_master_if.cyc;
            m_dat            = sel_dat;
            m_ack            = req & sel_ack;
            m_err            = req & sel_err;
            m_rty            = req & sel_rty;
        end else if (state == ST_ERR) begin
            m_err = 1'b1;
        end
    end

    assign wb_master_if.dat_i = m_dat;
    assign wb_master_if.ack   = m_ack;
    assign wb_master_if.err   = m_err;
    assign wb_master_if.rty   = m_rty;
    assign busy               = (state != ST_IDLE);
endmodule

// File: tb/tb_wb_mux_n.sv
// Bench for wb_mux_n: randomized transfers against a transaction-level timeline model
// (decode by address map, completion/timeout cycle computed from response delay).
module tb_wb_mux_n;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wishbone_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW)) wbm ();

    logic [NS*AW-1:0] wbs_adr_o, slv_addr, slv_msk;
    logic [NS*DW-1:0] wbs_dat_o, wbs_dat_i;
    logic [NS*SW-1:0] wbs_sel_o;
    logic [NS-1:0]    wbs_we_o, wbs_stb_o, wbs_cyc_o, wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic             busy, decode_err, timeout_err;

    wb_mux_n #(
        .NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .wb_master_if(wbm),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_dat_i(wbs_dat_i),
        .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i), .slv_addr(slv_addr), .slv_msk(slv_msk),
        .busy(busy), .decode_err(decode_err), .timeout_err(timeout_err)
    );

    logic [AW-1:0] map_addr [NS];
    logic [AW-1:0] map_msk  [NS];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int ref_decode(input logic [AW-1:0] a);
        for (int i = 0; i < NS; i++)
            if (((a ^ map_addr[i]) & map_msk[i]) == '0) return i;
        return -1;
    endfunction

    task automatic apply_map();
        for (int i = 0; i < NS; i++) begin
            slv_addr[i*AW +: AW] = map_addr[i];
            slv_msk[i*AW +: AW]  = map_msk[i];
        end
    endtask

    task automatic default_map();
        for (int i = 0; i < NS; i++) begin
            map_addr[i] = AW'(i) << 28;
            map_msk[i]  = 32'hF000_0000;
        end
        apply_map();
    endtask

    // kind: 0 ack, 1 err, 2 rty, 3 master abort at cycle dly+1 (needs dly < TO)
    task automatic xfer(input logic [AW-1:0] a, input logic w, input int dly,
                        input int kind, input bit noise);
        int idx, last, j;
        bit hit, tmo, act, errst, resp_now, abort_now;
        logic [AW-1:0] cur_adr;
        logic [DW-1:0] wdat;
        logic [SW-1:0] wsel;
        logic [NS-1:0] mask, exp_stb, exp_we;
        logic [DW-1:0] exp_dat;
        idx     = ref_decode(a);
        hit     = (idx >= 0);
        tmo     = hit && (dly >= TO);
        last    = !hit ? 2 : (tmo ? TO + 2 : dly + 2);
        cur_adr = a;
        wdat    = $urandom;
        wsel    = SW'($urandom);
        mask    = hit ? ~(NS'(1) << idx) : '1;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            abort_now  = (kind == 3) && (k == dly + 1);
            if (hit && k >= 2) cur_adr = $urandom;
            wbm.adr    = cur_adr;
            wbm.dat_o  = wdat;
            wbm.sel    = wsel;
            wbm.we     = w;
            wbm.cyc    = !(k == last || abort_now);
            wbm.stb    = !(k == last || abort_now);
            wbs_dat_i  = {$urandom, $urandom, $urandom, $urandom};
            wbs_ack_i  = noise ? (NS'($urandom) & mask) : '0;
            wbs_err_i  = noise ? (NS'($urandom) & mask) : '0;
            wbs_rty_i  = noise ? (NS'($urandom) & mask) : '0;
            if (hit && k == dly + 1) begin
                case (kind)
                    1:       wbs_err_i[idx] = 1'b1;
                    2:       wbs_rty_i[idx] = 1'b1;
                    default: wbs_ack_i[idx] = 1'b1;
                endcase
            end
            @(negedge clk);
            act      = hit && k >= 1 && k <= (tmo ? TO : dly + 1);
            errst    = (!hit && k == 1) || (tmo && k == TO + 1);
            resp_now = act && (k == dly + 1) && (kind != 3);
            exp_stb  = '0;
            exp_we   = '0;
            exp_dat  = '0;
            if (act && !abort_now) exp_stb[idx] = 1'b1;
            if (act && w)          exp_we[idx]  = 1'b1;
            if (act)               exp_dat      = wbs_dat_i[idx*DW +: DW];
            j = $urandom_range(0, NS - 1);
            check_eq("busy",        64'(busy),        64'(act || errst));
            check_eq("wbs_stb",     64'(wbs_stb_o),   64'(exp_stb));
            check_eq("wbs_cyc",     64'(wbs_cyc_o),   64'(exp_stb));
            check_eq("wbs_we",      64'(wbs_we_o),    64'(exp_we));
            check_eq("wbs_adr",     64'(wbs_adr_o[j*AW +: AW]), act ? 64'(cur_adr) : 64'd0);
            check_eq("wbs_dat",     64'(wbs_dat_o[j*DW +: DW]), act ? 64'(wdat) : 64'd0);
            check_eq("m_ack",       64'(wbm.ack),     64'(resp_now && kind == 0));
            check_eq("m_err",       64'(wbm.err),     64'(errst || (resp_now && kind == 1)));
            check_eq("m_rty",       64'(wbm.rty),     64'(resp_now && kind == 2));
            check_eq("m_dat",       64'(wbm.dat_i),   64'(exp_dat));
            check_eq("decode_err",  64'(decode_err),  64'(!hit && k == 0));
            check_eq("timeout_err", 64'(timeout_err), 64'(tmo && k == TO));
        end
    endtask

    initial begin
        wbm.adr = 32'h1000_0000; wbm.dat_o = '0; wbm.sel = '0; wbm.we = 1'b1;
        wbm.cyc = 1'b1; wbm.stb = 1'b1;
        wbs_dat_i = '1; wbs_ack_i = '1; wbs_err_i = '0; wbs_rty_i = '0;
        default_map();
        #1 rst = 1'b0;
        #12;
        check_eq("rst_busy",  64'(busy),      64'd0);
        check_eq("rst_stb",   64'(wbs_stb_o), 64'd0);
        check_eq("rst_cyc",   64'(wbs_cyc_o), 64'd0);
        check_eq("rst_adr",   64'(wbs_adr_o[AW-1:0]), 64'd0);
        check_eq("rst_ack",   64'(wbm.ack),   64'd0);
        check_eq("rst_err",   64'(wbm.err),   64'd0);
        check_eq("rst_dat",   64'(wbm.dat_i), 64'd0);
        wbm.cyc = 1'b0; wbm.stb = 1'b0; wbs_ack_i = '0; wbs_dat_i = '0;
        @(negedge clk); rst = 1'b1;

        xfer(32'h1000_0040, 1'b0, 2, 0, 1'b0);
        map_addr[2] = 32'h0000_0000; apply_map();
        xfer(32'h0000_0010, 1'b1, 1, 0, 1'b0);
        default_map();
        xfer(32'h5000_0000, 1'b0, 0, 0, 1'b1);
        xfer(32'h2000_0100, 1'b0, 20, 0, 1'b0);
        xfer(32'h3000_0004, 1'b1, 0, 0, 1'b0);
        xfer(32'h0000_0008, 1'b0, 3, 0, 1'b1);
        xfer(32'h1000_0000, 1'b0, TO - 1, 0, 1'b0);
        xfer(32'h1000_0000, 1'b0, TO, 0, 1'b0);
        xfer(32'h2000_0000, 1'b1, 1, 1, 1'b1);
        xfer(32'h3000_0000, 1'b0, 2, 2, 1'b1);
        xfer(32'h0000_0000, 1'b1, 2, 3, 1'b1);

        // Reset in the middle of an ACTIVE transfer
        @(posedge clk); #1;
        wbm.adr = 32'h2000_0010; wbm.we = 1'b0; wbm.cyc = 1'b1; wbm.stb = 1'b1;
        wbs_ack_i = '0; wbs_err_i = '0; wbs_rty_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("pre_rst_stb", 64'(wbs_stb_o), 64'h4);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_stb",  64'(wbs_stb_o), 64'd0);
        check_eq("mid_rst_cyc",  64'(wbs_cyc_o), 64'd0);
        check_eq("mid_rst_busy", 64'(busy),      64'd0);
        @(posedge clk); #1;
        wbm.cyc = 1'b0; wbm.stb = 1'b0;
        @(negedge clk); rst = 1'b1;
        xfer(32'h3000_0004, 1'b1, 1, 0, 1'b0);
        xfer(32'h2000_0000, 1'b0, TO + 5, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            int dly, kind, m;
            if (n % 8 == 0) begin
                for (int i = 0; i < NS; i++) begin
                    m = $urandom_range(0, 2);
                    map_msk[i]  = (m == 0) ? 32'hF000_0000 : (m == 1) ? 32'hC000_0000 : 32'hFF00_0000;
                    map_addr[i] = $urandom & map_msk[i];
                end
                apply_map();
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                m = $urandom_range(0, NS - 1);
                a = (a & ~map_msk[m]) | map_addr[m];
            end
            dly  = $urandom_range(0, TO + 2);
            kind = $urandom_range(0, 3);
            if (kind == 3 && dly >= TO) kind = 0;
            xfer(a, 1'($urandom), dly, kind, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
